// File: rtl/clk_div_meas.sv
// Measures period and high time of a slow square wave against clk.
// Also reports the divide setting (period-1), lock and a sticky timeout.
module clk_div_meas #(
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] div_n_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [0:0] {StIdle, StMeas} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s, sig_d_q, rise;
    logic [CNT_W-1:0]       cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d, high_q, high_d, div_q, div_d;
    logic                   valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
    // Set once a result exists since leaving idle, so lock compares real periods only
    logic                   prev_ok_q, prev_ok_d;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sig_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        div_d     = div_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        prev_ok_d = prev_ok_q;
        if (!en) begin
            state_d   = StIdle;
            cnt_d     = '0;
            hcnt_d    = '0;
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                    if (rise) begin
                        state_d = StMeas;
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                    end
                end
                StMeas: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        div_d     = cnt_q - CntOne;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        locked_d  = prev_ok_q && (cnt_q == period_q);
                        prev_ok_d = 1'b1;
                        cnt_d     = CntOne;
                        hcnt_d    = CntOne;
                    end else if (cnt_q == CntMax) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        prev_ok_d = 1'b0;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + CntOne;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, sig_s};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            div_q     <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            prev_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            div_q     <= div_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign div_n_out  = div_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
